// File: rtl/ps2_debouncer.sv
// Debounces one slow asynchronous line (PS/2 clock or data) into a clean level.
// The input is synchronized through two flops, then filtered by a stability counter.
module ps2_debouncer #(
    parameter int unsigned COUNT_MAX   = 19,
    parameter int unsigned COUNT_WIDTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic I,
    output logic O
);

    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    logic                   s1;
    logic                   s2;
    logic [COUNT_WIDTH-1:0] cnt;

    // Reset to the PS/2 idle level so no spurious edge is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            O   <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= I;
            s2 <= s1;
            if (s2 == O) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                O   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_debouncer.sv
// Randomized bench for ps2_debouncer: three parameterizations share one input and are
// compared every cycle against a history-window reference model.
module tb_ps2_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic I;
    logic o19;
    logic o0;
    logic o31;

    ps2_debouncer #(.COUNT_MAX(19), .COUNT_WIDTH(5)) u_dut19 (.clk(clk), .rst_n(rst_n), .I(I), .O(o19));
    ps2_debouncer #(.COUNT_MAX(0),  .COUNT_WIDTH(1)) u_dut0  (.clk(clk), .rst_n(rst_n), .I(I), .O(o0));
    ps2_debouncer #(.COUNT_MAX(31), .COUNT_WIDTH(5)) u_dut31 (.clk(clk), .rst_n(rst_n), .I(I), .O(o31));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n      = 0;     // index of the next rising edge
    int base   = 0;     // first edge after the most recent reset release

    bit hist [0:65535]; // level of I sampled at each edge
    bit om   [3];
    int lastf[3];
    int cmv  [3] = '{19, 0, 31};

    // Level presented at edge m; everything before the reset release reads as idle high.
    function automatic bit hval(input int m);
        if (m < base) return 1'b1;
        return hist[m];
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: edge %0d got %b expected %b", tag, n, got, exp);
        end
    endtask

    // The output flips at edge n when the synchronized level seen at each of the last
    // COUNT_MAX+1 edges (all since the previous flip) differed from the output.
    task automatic model_edge();
        hist[n] = I;
        for (int k = 0; k < 3; k++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j <= cmv[k]; j++) begin
                if ((n - j) <= lastf[k] || hval(n - j - 2) == om[k]) ok = 1'b0;
            end
            if (ok) begin
                om[k]    = ~om[k];
                lastf[k] = n;
            end
        end
    endtask

    task automatic cyc(input logic v);
        I = v;
        @(posedge clk);
        model_edge();
        n++;
        #1;
        check("O_cm19", o19, om[0]);
        check("O_cm0",  o0,  om[1]);
        check("O_cm31", o31, om[2]);
    endtask

    task automatic hold(input logic v, input int len);
        repeat (len) cyc(v);
    endtask

    task automatic do_reset();
        I     = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_O_cm19", o19, 1'b1);
        check("rst_O_cm0",  o0,  1'b1);
        check("rst_O_cm31", o31, 1'b1);
        repeat (3) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        base  = n;
        for (int k = 0; k < 3; k++) begin
            om[k]    = 1'b1;
            lastf[k] = base - 1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        I     = 1'b1;
        #1;
        do_reset();
        hold(1'b1, 50);

        // clean falling then rising transition
        hold(1'b0, 60);
        hold(1'b1, 60);

        // pulse-length threshold
        hold(1'b0, 19);
        hold(1'b1, 40);
        hold(1'b0, 20);
        hold(1'b1, 40);

        // bounce, then settle low
        for (int i = 0; i < 100; i++) cyc(((i / 3) % 2) == 1);
        hold(1'b0, 60);
        hold(1'b1, 60);

        // one-cycle return restarts the count
        hold(1'b0, 15);
        cyc(1'b1);
        hold(1'b0, 60);
        hold(1'b1, 60);

        // reset in the middle of a pending transition
        hold(1'b0, 10);
        do_reset();
        hold(1'b1, 30);

        // random held levels around the thresholds
        repeat (150) hold($urandom_range(0, 1) == 1, int'($urandom_range(1, 40)));
        // random fast bounce
        repeat (200) hold($urandom_range(0, 1) == 1, int'($urandom_range(1, 4)));
        hold(1'b1, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
